// File: rtl/iir_20k_pkg.sv
// Shared definitions for the 20 kHz biquad channel: FSM encoding, coefficient
// ROM selectors and the coefficient fixed-point scale.
package iir_20k_pkg;

    localparam int FRAC_BITS = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SEL_A0 = 4'b0000;
    localparam logic [3:0] SEL_A1 = 4'b0001;
    localparam logic [3:0] SEL_A2 = 4'b0010;
    localparam logic [3:0] SEL_B0 = 4'b0101;
    localparam logic [3:0] SEL_B1 = 4'b0110;
    localparam logic [3:0] SEL_B2 = 4'b0111;

    // MAC step k fetches b0,b1,b2 then a1,a2; a0 is never addressed.
    function automatic logic [3:0] sel_for_k(input logic [2:0] k);
        logic [3:0] sel;
        case (k)
            3'd0:    sel = SEL_B0;
            3'd1:    sel = SEL_B1;
            3'd2:    sel = SEL_B2;
            3'd3:    sel = SEL_A1;
            3'd4:    sel = SEL_A2;
            default: sel = SEL_A0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/iir_biquad_20k_if.sv
// Sample-side and coefficient-ROM-side signals of the 20 kHz biquad engine.
// The slave modport is the filter; the master modport is its environment.
interface iir_biquad_20k_if #(
    parameter int CANT_BITS = 25
);
    logic signed [CANT_BITS-1:0] x_in;
    logic                        sample_valid;
    logic signed [CANT_BITS-1:0] cte;
    logic [3:0]                  sel_cte;
    logic signed [CANT_BITS-1:0] y_out;
    logic                        y_valid;
    logic                        busy;
    logic                        overrun;

    modport master (
        output x_in,
        output sample_valid,
        output cte,
        input  sel_cte,
        input  y_out,
        input  y_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  x_in,
        input  sample_valid,
        input  cte,
        output sel_cte,
        output y_out,
        output y_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/iir_sat_trunc.sv
// Rescales the biquad accumulator by frac_bits (floor) and limits it to
// cant_bits. Define IIR_SAT_EN to saturate; otherwise the result wraps.
module iir_sat_trunc #(
    parameter int cant_bits = 25,
    parameter int frac_bits = 14
) (
    input  logic signed [2*cant_bits+2:0] acc_i,
    output logic signed [cant_bits-1:0]   y_o
);
    localparam int ACC_W = 2*cant_bits + 3;

`ifdef IIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (cant_bits-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (cant_bits-1)));

    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc_i >>> frac_bits;

    always_comb begin
        if (shifted > SAT_MAX) begin
            y_o = {1'b0, {(cant_bits-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            y_o = {1'b1, {(cant_bits-1){1'b0}}};
        end else begin
            y_o = shifted[cant_bits-1:0];
        end
    end
`else
    // Wrapping keeps only the bit window that survives the shift.
    assign y_o = acc_i[frac_bits +: cant_bits];

    logic unused_acc_bits;
    assign unused_acc_bits = ^{acc_i[ACC_W-1:frac_bits+cant_bits], acc_i[frac_bits-1:0]};
`endif

endmodule

// File: rtl/iir_biquad_20k.sv
// Sequential Direct-Form-I biquad: one shared multiplier, five MAC cycles per
// sample, coefficients fetched from an external combinational ROM. Output
// limiting saturates when IIR_SAT_EN is defined and wraps otherwise.
module iir_biquad_20k
    import iir_20k_pkg::*;
#(
    parameter int cant_bits = 25,
    parameter int frac_bits = FRAC_BITS
) (
    input  logic           clk,
    input  logic           reset,
    iir_biquad_20k_if.slave bus
);
    localparam int PROD_W = 2*cant_bits;
    localparam int ACC_W  = 2*cant_bits + 3;

    state_t                      state_q, state_d;
    logic [2:0]                  k_q, k_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [cant_bits-1:0] x0_q, x0_d;
    logic signed [cant_bits-1:0] x1_q, x1_d;
    logic signed [cant_bits-1:0] x2_q, x2_d;
    logic signed [cant_bits-1:0] y1_q, y1_d;
    logic signed [cant_bits-1:0] y2_q, y2_d;
    logic signed [cant_bits-1:0] y_out_q, y_out_d;
    logic                        y_valid_q, y_valid_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;
    logic [3:0]                  sel_cte_q, sel_cte_d;

    logic signed [cant_bits-1:0] operand;
    logic signed [PROD_W-1:0]    product;
    logic signed [ACC_W-1:0]     product_ext;
    logic signed [cant_bits-1:0] y_new;

    // The coefficient for step k is already on bus.cte because sel_cte_q
    // was loaded with that step's selector on the previous edge.
    always_comb begin
        operand = x0_q;
        case (k_q)
            3'd1:    operand = x1_q;
            3'd2:    operand = x2_q;
            3'd3:    operand = y1_q;
            3'd4:    operand = y2_q;
            default: operand = x0_q;
        endcase
    end

    assign product     = $signed(bus.cte) * operand;
    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    iir_sat_trunc #(
        .cant_bits (cant_bits),
        .frac_bits (frac_bits)
    ) u_sat_trunc (
        .acc_i (acc_q),
        .y_o   (y_new)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        acc_d     = acc_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;
        overrun_d = overrun_q;
        sel_cte_d = SEL_A0;

        if (bus.sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.sample_valid) begin
                    x0_d      = bus.x_in;
                    acc_d     = '0;
                    k_d       = 3'd0;
                    sel_cte_d = sel_for_k(3'd0);
                    state_d   = MAC;
                end
            end
            MAC: begin
                // b-terms add, a-terms subtract
                if (k_q < 3'd3) begin
                    acc_d = acc_q + product_ext;
                end else begin
                    acc_d = acc_q - product_ext;
                end
                if (k_q == 3'd4) begin
                    state_d = DONE;
                end else begin
                    k_d       = k_q + 3'd1;
                    sel_cte_d = sel_for_k(k_q + 3'd1);
                end
            end
            DONE: begin
                y_out_d   = y_new;
                y_valid_d = 1'b1;
                x2_d      = x1_q;
                x1_d      = x0_q;
                y2_d      = y1_q;
                y1_d      = y_new;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            k_q       <= 3'd0;
            acc_q     <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            sel_cte_q <= SEL_A0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            sel_cte_q <= sel_cte_d;
        end
    end

    assign bus.sel_cte = sel_cte_q;
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_iir_biquad_20k.sv
// Self-checking bench for iir_biquad_20k: impulse, latency, overrun, reset
// mid-MAC, saturation/wrap and randomized samples against an equation model.
module tb_iir_biquad_20k;
    import iir_20k_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_samples;
    bit   ovr_exp;

    logic signed [24:0] rom [16];
    longint mx1, mx2, my1, my2;

    iir_biquad_20k_if #(.CANT_BITS(25)) bus ();

    assign bus.cte = rom[bus.sel_cte];

    iir_biquad_20k dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endfunction

    // y[n] = b0 x[n] + b1 x[n-1] + b2 x[n-2] - a1 y[n-1] - a2 y[n-2], scaled by 2^-14 (floor)
    function automatic longint model_step(input longint x);
        longint acc;
        longint s;
        acc = longint'(rom[SEL_B0]) * x + longint'(rom[SEL_B1]) * mx1
            + longint'(rom[SEL_B2]) * mx2 - longint'(rom[SEL_A1]) * my1
            - longint'(rom[SEL_A2]) * my2;
        s = acc >>> 14;
`ifdef IIR_SAT_EN
        if (s > 64'sd16777215) s = 64'sd16777215;
        else if (s < -64'sd16777216) s = -64'sd16777216;
`else
        s = s & 64'sh1FFFFFF;
        if (s >= 64'sd16777216) s = s - 64'sd33554432;
`endif
        mx2 = mx1; mx1 = x;
        my2 = my1; my1 = s;
        return s;
    endfunction

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
        for (int i = 0; i < 16; i++) rom[i] = 25'($urandom);
        rom[SEL_A0] = 25'h0ABCDE;
        rom[SEL_B0] = 25'(b0);
        rom[SEL_B1] = 25'(b1);
        rom[SEL_B2] = 25'(b2);
        rom[SEL_A1] = 25'(a1);
        rom[SEL_A2] = 25'(a2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        ovr_exp = 1'b0;
    endtask

    // One sample through the engine; ovr_at>0 raises a stray sample_valid
    // that is sampled at edge E<ovr_at>.
    task automatic do_sample(input logic signed [24:0] x, input int ovr_at, output longint y_obs);
        logic [19:0] sel_seq;
        int busy_cnt;
        int vld_cnt;
        longint exp_y;
        exp_y = model_step(longint'(x));
        sel_seq = '0;
        busy_cnt = 0;
        vld_cnt = 0;
        @(negedge clk);
        bus.x_in = x;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sel_seq = {sel_seq[15:0], bus.sel_cte};
            else check("done_sel", longint'(bus.sel_cte), 0);
            busy_cnt += int'(bus.busy);
            vld_cnt += int'(bus.y_valid);
            bus.sample_valid = ((i + 1) == ovr_at);
            if ((i + 1) == ovr_at) bus.x_in = 25'($urandom);
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        if (ovr_at > 0) ovr_exp = 1'b1;
        check("sel_seq", longint'(sel_seq), longint'(20'h56712));
        check("busy_e0_e5", longint'(busy_cnt), 6);
        check("early_valid", longint'(vld_cnt), 0);
        check("y_valid_e6", longint'(bus.y_valid), 1);
        check("busy_fall_e6", longint'(bus.busy), 0);
        check("overrun", longint'(bus.overrun), longint'(ovr_exp));
        y_obs = longint'(bus.y_out);
        check("y_out", y_obs, exp_y);
        n_samples++;
        $display("sample %0d x=%0d y=%0d exp=%0d overrun=%0d", n_samples, x, y_obs, exp_y, bus.overrun);
        @(negedge clk);
        check("y_valid_pulse", longint'(bus.y_valid), 0);
    endtask

    initial begin
        longint y;
        longint y_first;
        checks = 0;
        errors = 0;
        n_samples = 0;
        ovr_exp = 1'b0;
        rst_n = 1'b0;
        bus.x_in = '0;
        bus.sample_valid = 1'b0;
        model_clear();
        set_coefs(32'h340B, 32'hEEE7, 32'h1234, 32'h4000, 32'h2000);

        repeat (3) @(negedge clk);
        check("rst_y_out", longint'(bus.y_out), 0);
        check("rst_y_valid", longint'(bus.y_valid), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_overrun", longint'(bus.overrun), 0);
        check("rst_sel", longint'(bus.sel_cte), 0);
        rst_n = 1'b1;

        // impulse
        do_sample(25'h0004000, 0, y);
        check("impulse_y0", y, 64'h340B);
        do_sample(25'h0000000, 0, y);
        check("impulse_y1", y, 64'hBADC);
        do_sample(25'h0000000, 0, y);

        // stray sample_valid mid-MAC and during DONE
        do_sample(25'h0012345, 3, y);
        do_sample(-25'sd7000, 0, y);
        do_sample(25'h0003000, 6, y);
        do_sample(25'h0000100, 0, y);

        // reset asserted just after E2 of a sample in flight
        @(negedge clk);
        bus.x_in = 25'h0004000;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", longint'(bus.busy), 0);
        check("midrst_sel", longint'(bus.sel_cte), 0);
        check("midrst_overrun", longint'(bus.overrun), 0);
        check("midrst_y_out", longint'(bus.y_out), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_valid", longint'(bus.y_valid), 0);
        end
        rst_n = 1'b1;
        model_clear();
        ovr_exp = 1'b0;
        do_sample(25'h0004000, 0, y);
        check("post_rst_y0", y, 64'h340B);
        do_sample(25'h0000000, 0, y);
        check("post_rst_y1", y, 64'hBADC);

        // saturation / wrap on a full-scale constant input
        do_reset();
        do_sample(25'h0FFFFFF, 0, y_first);
        do_sample(25'h0FFFFFF, 0, y);
`ifdef IIR_SAT_EN
        check("sat_y1", y, 64'h0FFFFFF);
`else
        check("wrap_y1_differs", longint'(y == 64'h0FFFFFF), 0);
`endif
        do_sample(25'h0FFFFFF, 0, y);

        // randomized coefficients and samples
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            set_coefs(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 32767)) - 16384,
                      int'($urandom_range(0, 16383)) - 8192);
            for (int n = 0; n < 10; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (n == 5) do_sample(25'($urandom), 0, y);
                else do_sample(25'(int'($urandom_range(0, 2000000)) - 1000000), 0, y);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
